// File: rtl/risc_test_loader.sv
// risc_test_loader: bring-up harness for Single_Cycle_RISC.
// It loads the CPU's instruction and data memories and runs the CPU until HLT or timeout.
// Every change of the CPU OutR value is captured into a trace FIFO.
// Optional feature: define TRACE_TIMESTAMP_EN to prefix each trace entry with cycle_counter[15:0].
// Ports:
//   clk_i, clr_i                       clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o            command handshake
//   cmd_op_i, cmd_addr_i, cmd_data_i   00 wr instr, 01 wr data, 10 run, 11 ignored
//   abort_i                            leave START/RUN for IDLE
//   test_normal_o, cpu_clr_o           CPU memory-load mode and CPU reset
//   ext_{instr,data}_{we,addr,data}_o  one-cycle registered memory write ports
//   cpu_outr_i, cpu_done_i             CPU observation inputs
//   trace_valid_o/trace_ready_i        trace FIFO pop handshake
//   trace_data_o                       trace FIFO head
//   busy_o, halted_o, timeout_o, trace_ovf_o   status; the last three are sticky
module risc_test_loader #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int TRACE_DEPTH = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit HALT_LEVEL = 1'b0,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TW = DW + 16
`else
    localparam int TW = DW
`endif
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_data_i,
    input  logic          abort_i,
    output logic          test_normal_o,
    output logic          ext_instr_we_o,
    output logic [AW-1:0] ext_instr_addr_o,
    output logic [DW-1:0] ext_instr_data_o,
    output logic          ext_data_we_o,
    output logic [AW-1:0] ext_data_addr_o,
    output logic [DW-1:0] ext_data_data_o,
    output logic          cpu_clr_o,
    input  logic [DW-1:0] cpu_outr_i,
    input  logic          cpu_done_i,
    output logic          trace_valid_o,
    input  logic          trace_ready_i,
    output logic [TW-1:0] trace_data_o,
    output logic          busy_o,
    output logic          halted_o,
    output logic          timeout_o,
    output logic          trace_ovf_o
);
    localparam int PW = $clog2(TRACE_DEPTH);
    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_HALTED, S_TIMEOUT} state_t;
    state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [DW-1:0] last_q, last_d, wdata_q;
    logic [AW-1:0] waddr_q;
    logic iwe_q, dwe_q, halted_q, halted_d, timeout_q, timeout_d, ovf_q, ovf_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0] fcnt_q, fcnt_d;
    logic [TW-1:0] mem [TRACE_DEPTH];
    logic fire, run_acc, wr_acc, in_run, halt_hit, to_hit, chg, full, pop, push;
    logic [TW-1:0] entry;

    assign cmd_ready_o = state_q inside {S_IDLE, S_HALTED, S_TIMEOUT};
    assign test_normal_o = state_q == S_IDLE;
    assign cpu_clr_o = state_q inside {S_IDLE, S_START, S_TIMEOUT};
    assign busy_o = state_q inside {S_START, S_RUN};
    assign halted_o = halted_q;
    assign timeout_o = timeout_q;
    assign trace_ovf_o = ovf_q;
    assign ext_instr_we_o = iwe_q;
    assign ext_data_we_o = dwe_q;
    assign ext_instr_addr_o = waddr_q;
    assign ext_data_addr_o = waddr_q;
    assign ext_instr_data_o = wdata_q;
    assign ext_data_data_o = wdata_q;
    assign trace_valid_o = fcnt_q != '0;
    assign trace_data_o = mem[rptr_q];
`ifdef TRACE_TIMESTAMP_EN
    assign entry = {cnt_q[15:0], cpu_outr_i};
`else
    assign entry = cpu_outr_i;
`endif

    always_comb begin
        fire = cmd_valid_i & cmd_ready_o;
        run_acc = fire & (cmd_op_i == 2'b10);
        wr_acc = fire & ~cmd_op_i[1];
        in_run = state_q == S_RUN;
        // Halt has priority over timeout when both occur in the same cycle.
        halt_hit = in_run & ~abort_i & (cpu_done_i == HALT_LEVEL);
        to_hit = in_run & ~abort_i & ~halt_hit & (cnt_q == 32'(TIMEOUT_CYC - 1));
        state_d = run_acc ? S_START :
                  wr_acc ? S_IDLE :
                  (busy_o & abort_i) ? S_IDLE :
                  (state_q == S_START) ? S_RUN :
                  halt_hit ? S_HALTED :
                  to_hit ? S_TIMEOUT : state_q;
        // The counter also advances in START, so timeout lands TIMEOUT_CYC cycles after START.
        cnt_d = run_acc ? '0 : busy_o ? cnt_q + 32'd1 : cnt_q;
        chg = in_run & (cpu_outr_i != last_q);
        last_d = (state_q == S_START || chg) ? cpu_outr_i : last_q;
        halted_d = ~run_acc & (halted_q | halt_hit);
        timeout_d = ~run_acc & (timeout_q | to_hit);
        full = fcnt_q == (PW+1)'(TRACE_DEPTH);
        pop = trace_valid_o & trace_ready_i;
        // A pop in the same cycle frees a slot, so a push to a full FIFO still fits.
        push = chg & (~full | pop);
        ovf_d = ovf_q | (chg & full & ~pop);
        fcnt_d = fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            last_q <= '0;
            iwe_q <= 1'b0;
            dwe_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            halted_q <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            iwe_q <= wr_acc & ~cmd_op_i[0];
            dwe_q <= wr_acc & cmd_op_i[0];
            waddr_q <= wr_acc ? cmd_addr_i : waddr_q;
            wdata_q <= wr_acc ? cmd_data_i : wdata_q;
            halted_q <= halted_d;
            timeout_q <= timeout_d;
            ovf_q <= ovf_d;
            wptr_q <= push ? wptr_q + 1'b1 : wptr_q;
            rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
            fcnt_q <= fcnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= entry;
    end
endmodule

// File: tb/tb_risc_test_loader.sv
// tb_risc_test_loader: directed self-checking bench for risc_test_loader.
module tb_risc_test_loader;
    logic clk = 1'b0;
    logic clr = 1'b0, cmd_valid = 1'b0, abort = 1'b0, cpu_done = 1'b1, trace_ready = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [15:0] cmd_addr = '0, cmd_data = '0, cpu_outr = '0;
    logic cmd_ready, test_normal, iwe, dwe, cpu_clr, trace_valid, busy, halted, timeout, ovf;
    logic [15:0] iaddr, idata, daddr, ddata;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] trace_data;
`else
    logic [15:0] trace_data;
`endif
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    risc_test_loader #(.DW(16), .AW(16), .TRACE_DEPTH(4), .TIMEOUT_CYC(64), .HALT_LEVEL(1'b0)) dut (
        .clk_i(clk), .clr_i(clr), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .abort_i(abort),
        .test_normal_o(test_normal),
        .ext_instr_we_o(iwe), .ext_instr_addr_o(iaddr), .ext_instr_data_o(idata),
        .ext_data_we_o(dwe), .ext_data_addr_o(daddr), .ext_data_data_o(ddata),
        .cpu_clr_o(cpu_clr), .cpu_outr_i(cpu_outr), .cpu_done_i(cpu_done),
        .trace_valid_o(trace_valid), .trace_ready_i(trace_ready), .trace_data_o(trace_data),
        .busy_o(busy), .halted_o(halted), .timeout_o(timeout), .trace_ovf_o(ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        clr = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00;
        tick();
        cmd_valid = 1'b0; clr = 1'b0;
        chk("rst_test_normal", test_normal, 1); chk("rst_cpu_clr", cpu_clr, 1);
        chk("rst_iwe", iwe, 0); chk("rst_dwe", dwe, 0); chk("rst_addr", iaddr, 0);
        chk("rst_data", idata, 0); chk("rst_tvalid", trace_valid, 0); chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0); chk("rst_timeout", timeout, 0); chk("rst_ovf", ovf, 0);
        chk("rst_ready", cmd_ready, 1);
        cmd(2'b00, 16'h0000, 16'h1234);
        chk("wi_we", iwe, 1); chk("wi_addr", iaddr, 16'h0000); chk("wi_data", idata, 16'h1234);
        chk("wi_dwe", dwe, 0);
        tick();
        chk("wi_we_one", iwe, 0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 16'h0010; cmd_data = 16'h0047;
        tick();
        chk("wd0_we", dwe, 1); chk("wd0_addr", daddr, 16'h0010); chk("wd0_data", ddata, 16'h0047);
        cmd_addr = 16'h0011; cmd_data = 16'h0089;
        tick();
        cmd_valid = 1'b0;
        chk("wd1_we", dwe, 1); chk("wd1_addr", daddr, 16'h0011); chk("wd1_data", ddata, 16'h0089);
        chk("wd1_iwe", iwe, 0);
        tick();
        chk("wd_we_end", dwe, 0);
        cmd(2'b11, 16'h0005, 16'h5555);
        chk("rsv_iwe", iwe, 0); chk("rsv_dwe", dwe, 0); chk("rsv_ready", cmd_ready, 1);
        chk("rsv_idle", test_normal, 1);
        cmd(2'b10, 16'h0, 16'h0);
        chk("start_busy", busy, 1); chk("start_clr", cpu_clr, 1); chk("start_tn", test_normal, 0);
        chk("start_ready", cmd_ready, 0);
        tick();
        chk("run_clr", cpu_clr, 0); chk("run_busy", busy, 1);
        cpu_outr = 16'h0047; tick(); tick();
        chk("tr_valid", trace_valid, 1);
        cpu_outr = 16'h0089; tick(); tick();
        cpu_outr = 16'h00D0; tick();
        cpu_done = 1'b0; tick(); cpu_done = 1'b1;
        chk("halt_flag", halted, 1); chk("halt_busy", busy, 0); chk("halt_clr", cpu_clr, 0);
        chk("halt_ready", cmd_ready, 1);
        trace_ready = 1'b1;
        chk("tr0", trace_data[15:0], 16'h0047); tick();
        chk("tr1", trace_data[15:0], 16'h0089); tick();
        chk("tr2", trace_data[15:0], 16'h00D0); tick();
        chk("tr_empty", trace_valid, 0);
        trace_ready = 1'b0;
        cmd(2'b10, 16'h0, 16'h0);
        chk("rerun_halted_clr", halted, 0);
        repeat (63) tick();
        chk("to_early", timeout, 0); chk("to_early_busy", busy, 1);
        tick();
        chk("to_flag", timeout, 1); chk("to_clr", cpu_clr, 1); chk("to_busy", busy, 0);
        chk("to_no_trace", trace_valid, 0);
        cmd(2'b10, 16'h0, 16'h0);
        chk("rerun_to_clr", timeout, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            cpu_outr = 16'(i);
            tick();
        end
        chk("full_no_ovf", ovf, 0);
        trace_ready = 1'b1; cpu_outr = 16'h0005; tick();
        chk("pp_no_ovf", ovf, 0); chk("pp_head", trace_data[15:0], 16'h0002);
        trace_ready = 1'b0; cpu_outr = 16'h0006; tick();
        chk("ovf_flag", ovf, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_busy", busy, 0); chk("ab_halted", halted, 0); chk("ab_tn", test_normal, 1);
        chk("ab_clr", cpu_clr, 1);
        trace_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("ab_pop", trace_data[15:0], 16'(i));
            tick();
        end
        chk("ab_empty", trace_valid, 0);
        trace_ready = 1'b0;
        cmd(2'b10, 16'h0, 16'h0);
        tick();
        cpu_outr = 16'h0007; tick();
        chk("pre_clr_valid", trace_valid, 1);
        clr = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00;
        tick();
        clr = 1'b0; cmd_valid = 1'b0;
        chk("clr_tn", test_normal, 1); chk("clr_cpu_clr", cpu_clr, 1); chk("clr_busy", busy, 0);
        chk("clr_tvalid", trace_valid, 0); chk("clr_ovf", ovf, 0); chk("clr_iwe", iwe, 0);
        chk("clr_timeout", timeout, 0); chk("clr_halted", halted, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
